// File: rtl/cpu_inst_encoder_if.sv
// Bundles the program-load handshake, instruction-memory write port and status
// of cpu_inst_encoder. The encoder takes the slave side.
interface cpu_inst_encoder_if;
   logic        start;
   logic        in_valid;
   logic [3:0]  opcode;
   logic [3:0]  input_A;
   logic [3:0]  input_B;
   logic        last;
   logic        in_ready;
   logic        mem_we;
   logic [3:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        full;
   logic [4:0]  count;

   modport master (
      output start, in_valid, opcode, input_A, input_B, last,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, full, count
   );

   modport slave (
      input  start, in_valid, opcode, input_A, input_B, last,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done, full, count
   );
endinterface

// File: rtl/cpu_inst_encoder.sv
// Packs {opcode, A, B, PAD} triples into 16-bit words and writes them to
// consecutive instruction-memory addresses, one program load at a time.
module cpu_inst_encoder #(
   parameter int unsigned DEPTH = 16,
   parameter logic [3:0]  PAD   = 4'b0000
) (
   input  logic               clk,
   input  logic               rst,
   cpu_inst_encoder_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_PTR = 4'(DEPTH - 1);

   state_t      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [4:0]  count_q, count_d;
   logic        full_q, full_d;
   logic        we_q, we_d;
   logic [3:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;

   function automatic logic [15:0] pack_word(input logic [3:0] op,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
      return {op, a, b, PAD};
   endfunction

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      full_d  = full_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = LOAD;
               ptr_d   = 4'd0;
               count_d = 5'd0;
               full_d  = 1'b0;
            end
         end
         LOAD: begin
            if (bus.in_valid) begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = pack_word(bus.opcode, bus.input_A, bus.input_B);
               ptr_d   = ptr_q + 4'd1;
               count_d = count_q + 5'd1;
               // Filling the last slot ends the load even without 'last'.
               if (ptr_q == LAST_PTR) begin
                  state_d = DONE;
                  full_d  = 1'b1;
               end else if (bus.last) begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 4'd0;
         count_q <= 5'd0;
         full_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 4'd0;
         wdata_q <= 16'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.in_ready  = (state_q == LOAD);
   assign bus.busy      = (state_q == LOAD);
   assign bus.done      = (state_q == DONE);
   assign bus.full      = full_q;
   assign bus.count     = count_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule

// File: doc/cpu_inst_encoder.md
CPU_INST_ENCODER -- requirements
Module: cpu_inst_encoder

Interface
REQ-001 Parameter DEPTH, default 16, meaning number of instruction-memory words the encoder may write (power of two, 2..16).
REQ-002 Parameter PAD, default 4'b0000, meaning fixed value placed in word bits [3:0].
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin a new program load (sampled in IDLE and DONE only).
REQ-006 in_valid  input  1  upstream presents a field triple this cycle.
REQ-007 opcode  input  4  instruction opcode field.
REQ-008 input_A  input  4  first operand field.
REQ-009 input_B  input  4  second operand field.
REQ-010 last  input  1  qualifies with in_valid; marks final instruction of the program.
REQ-011 in_ready  output  1  encoder accepts a triple this cycle.
REQ-012 mem_we  output  1  registered write strobe to instruction memory.
REQ-013 mem_addr  output  4  registered write address.
REQ-014 mem_wdata  output  16  registered packed instruction word.
REQ-015 busy  output  1  high while in LOAD.
REQ-016 done  output  1  high while in DONE.
REQ-017 full  output  1  high in DONE when the load ended because DEPTH words were written.
REQ-018 count  output  5  number of words written in current/last load (0..DEPTH).

Function
REQ-019 FSM states SHALL be IDLE, LOAD, DONE; encoding free.
REQ-020 IDLE: start=1 -> LOAD next cycle, internal write pointer and count cleared to 0, full cleared.
REQ-021 DONE: start=1 -> LOAD next cycle with same clearing as REQ-020; start=0 -> remain in DONE.
REQ-022 start in LOAD SHALL be ignored.
REQ-023 in_ready SHALL be 1 exactly when state is LOAD (combinational from state only, not from in_valid).
REQ-024 Accept occurs on a cycle with in_valid=1 and in_ready=1; fields with in_valid=0 or outside LOAD SHALL be ignored.
REQ-025 On accept at cycle N, in cycle N+1: mem_we=1, mem_addr=pointer value at N, mem_wdata={opcode,input_A,input_B,PAD}, count=count+1.
REQ-026 mem_we SHALL be 1 only the cycle after an accept; back-to-back accepts give consecutive single-cycle strobes with incrementing addresses.
REQ-027 mem_addr and mem_wdata SHALL hold their last written value when mem_we=0.
REQ-028 Pointer increments by 1 per accept; never wraps within one load.
REQ-029 Accept with last=1 -> DONE next cycle, full=0 (unless REQ-030 also applies).
REQ-030 Accept at pointer DEPTH-1 -> DONE next cycle, full=1, regardless of last.
REQ-031 In DONE in_ready=0, so at most DEPTH words are written per load.
REQ-032 busy=1 iff LOAD; done=1 iff DONE; busy and done never both 1.
REQ-033 count SHALL hold its value through DONE until the next start.

Reset
REQ-034 rst=1 at a clock edge: state IDLE; mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, full=0, count=0, pointer=0.
REQ-035 rst SHALL take priority over start and accepts in the same cycle, including mid-LOAD; no mem_we is issued after the reset edge for a triple accepted in that cycle.
REQ-036 After rst deasserts, block stays in IDLE until start.

Verification
REQ-037 Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, in_ready=0.
REQ-038 Three-word load: start; accept (1,2,3),(4,5,6),(7,8,9 last) back-to-back -> mem_we on 3 consecutive cycles, addr 0,1,2, wdata 16'h1230,16'h4560,16'h7890; then done=1, full=0, count=3.
REQ-039 Gapped valid: in_valid toggling 1,0,1 with last on 2nd word -> exactly 2 strobes, addr 0,1, no strobe on idle cycle.
REQ-040 Full: DEPTH=16, 20 consecutive valid triples, last=0 -> 16 strobes addr 0..15, in_ready=0 after 16th accept, done=1, full=1, count=16.
REQ-041 Mid-load reset: rst=1 on cycle of 2nd accept -> no strobe for that word, all outputs 0 next cycle; new start reloads from addr 0.
REQ-042 Restart: in DONE assert start, load one word with last -> addr 0, count=1, full=0; start during LOAD has no effect.
